// File: rtl/ball_move_if.sv
// Handshake/bus bundle between the pong controller and the ball engine.
// The scorer drives halt from its win flags.
interface ball_move_if;
  logic       start;
  logic       halt;
  logic [7:0] Lftpaddle;
  logic [7:0] Rgtpaddle;
  logic [7:0] ball_x;
  logic [7:0] ball_y;
  logic       Lftcollision;
  logic       Rgtcollision;

  modport master (
    output start, halt, Lftpaddle, Rgtpaddle,
    input  ball_x, ball_y, Lftcollision, Rgtcollision
  );
  modport slave (
    input  start, halt, Lftpaddle, Rgtpaddle,
    output ball_x, ball_y, Lftcollision, Rgtcollision
  );
endinterface

// File: rtl/ball_move.sv
// Pong ball engine: steps the ball once per TICK_DIV clocks, bounces it off the
// walls and paddles, and emits a one-clock miss pulse towards the scorer.
module ball_move #(
  parameter int H_MAX      = 160,
  parameter int V_MAX      = 120,
  parameter int PADDLE_LEN = 16,
  parameter int TICK_DIV   = 500000
) (
  input  logic        clk,
  input  logic        reset,
  ball_move_if.slave  bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0] X_C   = 8'(H_MAX / 2);
  localparam logic [7:0] Y_C   = 8'(V_MAX / 2);
  localparam logic [7:0] X_RCK = 8'(H_MAX - 2);
  localparam logic [7:0] X_RIN = 8'(H_MAX - 3);
  localparam logic [7:0] Y_BOT = 8'(V_MAX - 1);
  localparam logic [7:0] Y_BIN = 8'(V_MAX - 2);

  typedef enum logic [1:0] {IDLE, RUN, SCORE, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          dxn_q, dxn_d, dyn_q, dyn_d;  // 1 = moving towards 0
  logic          lcol_q, lcol_d, rcol_q, rcol_d;

  logic       tick, lchk, rchk, lhit, rhit, miss_l, miss_r;
  logic [8:0] y9, lp_hi, rp_hi;
  logic [7:0] y_nxt;
  logic       dyn_nxt;

  // Paddle range compared at 9 bits so P+PADDLE_LEN-1 cannot wrap past 255
  assign y9     = {1'b0, y_q};
  assign lp_hi  = {1'b0, bus.Lftpaddle} + 9'(PADDLE_LEN - 1);
  assign rp_hi  = {1'b0, bus.Rgtpaddle} + 9'(PADDLE_LEN - 1);
  assign lhit   = (y9 >= {1'b0, bus.Lftpaddle}) && (y9 <= lp_hi);
  assign rhit   = (y9 >= {1'b0, bus.Rgtpaddle}) && (y9 <= rp_hi);
  assign tick   = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign lchk   = (x_q == 8'd1) && dxn_q;
  assign rchk   = (x_q == X_RCK) && !dxn_q;
  assign miss_l = tick && lchk && !lhit;
  assign miss_r = tick && rchk && !rhit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= X_C;
      y_q     <= Y_C;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      lcol_q  <= 1'b0;
      rcol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      lcol_q  <= lcol_d;
      rcol_q  <= rcol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.halt) state_d = STOP;
    else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = RUN;
        RUN:     if (miss_l || miss_r) state_d = SCORE;
        SCORE:   state_d = IDLE;
        default: state_d = STOP;
      endcase
    end
  end

  always_comb begin
    y_nxt   = dyn_q ? (y_q - 8'd1) : (y_q + 8'd1);
    dyn_nxt = dyn_q;
    if ((y_q == 8'd0) && dyn_q) begin
      y_nxt   = 8'd1;
      dyn_nxt = 1'b0;
    end else if ((y_q == Y_BOT) && !dyn_q) begin
      y_nxt   = Y_BIN;
      dyn_nxt = 1'b1;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    dxn_d  = dxn_q;
    dyn_d  = dyn_q;
    lcol_d = 1'b0;
    rcol_d = 1'b0;
    // halt freezes everything, including a coincident move tick or miss
    if (!bus.halt) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          x_d   = X_C;
          y_d   = Y_C;
        end
        RUN: begin
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (miss_l || miss_r) begin
            x_d    = X_C;
            y_d    = Y_C;
            dxn_d  = miss_l;
            lcol_d = miss_l;
            rcol_d = miss_r;
          end else if (tick) begin
            y_d   = y_nxt;
            dyn_d = dyn_nxt;
            if (lchk) begin
              x_d   = 8'd2;
              dxn_d = 1'b0;
            end else if (rchk) begin
              x_d   = X_RIN;
              dxn_d = 1'b1;
            end else begin
              x_d = dxn_q ? (x_q - 8'd1) : (x_q + 8'd1);
            end
          end
        end
        SCORE:   cnt_d = '0;
        default: ;
      endcase
    end
  end

  assign bus.ball_x       = x_q;
  assign bus.ball_y       = y_q;
  assign bus.Lftcollision = lcol_q;
  assign bus.Rgtcollision = rcol_q;
endmodule
